// File: rtl/modemux_pkg.sv
// Shared definitions for the request queue that feeds the 4-input grant mux.
package modemux_pkg;

  // Number of request channels presented to the downstream mux.
  localparam int NUM_CH = 4;

  // Default data word width; must match the downstream mux.
  localparam int DATA_WIDTH_DEF = 8;

  // Per-channel handshake state. OFFER drives req for one mux sample;
  // WAIT covers the cycle in which the mux's registered grant comes back.
  typedef enum logic {
    OFFER = 1'b0,
    WAIT  = 1'b1
  } chan_state_e;

endpackage : modemux_pkg

// File: rtl/req_chan_fifo.sv
// Single request channel: circular FIFO plus an OFFER/WAIT handshake FSM.
// The head word is offered to the mux for exactly one sample, then the
// channel waits one cycle for the registered grant and pops only if granted.
module req_chan_fifo
  import modemux_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int DEPTH      = 4,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  grant,
  output logic                  req,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic [CW-1:0]         level,
  output logic                  ovf
);

  // Storage is data only: it is never reset, because an empty channel
  // masks the head word to zero and level/pointers define validity.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] level_q,  level_d;
  logic          ovf_q,    ovf_d;
  chan_state_e   state_q,  state_d;

  logic is_full;
  logic is_empty;
  logic push_ok;
  logic pop;

  // Occupancy flags and the accept/pop decisions for this cycle.
  always_comb begin
    is_full  = (level_q == CW'(DEPTH));
    is_empty = (level_q == '0);
    // A push on a full channel is dropped even if a pop happens this cycle.
    push_ok  = push && !is_full;
    // Only a grant that answers our own offer (we are in WAIT) pops the head.
    pop      = (state_q == WAIT) && grant;
  end

  // Next pointer, level and sticky overflow values.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Push and pop together leave the level unchanged; pop implies level>=1.
    level_d = level_q + CW'(push_ok) - CW'(pop);
    if (push && is_full) begin
      ovf_d = 1'b1;
    end
  end

  // Handshake FSM next state and request output.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (state_q)
      OFFER: begin
        req = !is_empty;
        if (!is_empty) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Grant (if any) is consumed by the pop logic; always re-offer next.
        state_d = OFFER;
      end
      default: begin
        state_d = OFFER;
      end
    endcase
  end

  // Head word: held at mem[rd_ptr] through WAIT, zero when empty.
  always_comb begin
    data_in = '0;
    if (!is_empty) begin
      data_in = mem_q[rd_ptr_q];
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= OFFER;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
    end
  end

  // Data storage write port, only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign full  = is_full;
  assign level = level_q;
  assign ovf   = ovf_q;

endmodule : req_chan_fifo

// File: rtl/req_fifo_bank.sv
// Four-channel request queue in front of the 4-input grant mux.
// Pure wiring: one req_chan_fifo per channel, flattened to per-channel ports.
module req_fifo_bank
  import modemux_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int DEPTH      = 4,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     push,
  input  logic [DATA_WIDTH-1:0] push_data0,
  input  logic [DATA_WIDTH-1:0] push_data1,
  input  logic [DATA_WIDTH-1:0] push_data2,
  input  logic [DATA_WIDTH-1:0] push_data3,
  input  logic [NUM_CH-1:0]     grant,
  output logic [NUM_CH-1:0]     req,
  output logic [DATA_WIDTH-1:0] data_in0,
  output logic [DATA_WIDTH-1:0] data_in1,
  output logic [DATA_WIDTH-1:0] data_in2,
  output logic [DATA_WIDTH-1:0] data_in3,
  output logic [NUM_CH-1:0]     full,
  output logic [CW-1:0]         level0,
  output logic [CW-1:0]         level1,
  output logic [CW-1:0]         level2,
  output logic [CW-1:0]         level3,
  output logic [NUM_CH-1:0]     ovf
);

  logic [DATA_WIDTH-1:0] pdata [NUM_CH];
  logic [DATA_WIDTH-1:0] head  [NUM_CH];
  logic [CW-1:0]         lvl   [NUM_CH];

  assign pdata[0] = push_data0;
  assign pdata[1] = push_data1;
  assign pdata[2] = push_data2;
  assign pdata[3] = push_data3;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    req_chan_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .push     (push[i]),
      .push_data(pdata[i]),
      .grant    (grant[i]),
      .req      (req[i]),
      .data_in  (head[i]),
      .full     (full[i]),
      .level    (lvl[i]),
      .ovf      (ovf[i])
    );
  end

  assign data_in0 = head[0];
  assign data_in1 = head[1];
  assign data_in2 = head[2];
  assign data_in3 = head[3];

  assign level0 = lvl[0];
  assign level1 = lvl[1];
  assign level2 = lvl[2];
  assign level3 = lvl[3];

endmodule : req_fifo_bank

// File: tb/tb_req_fifo_bank.sv
// Directed bench for req_fifo_bank with a registered-grant mux model in the loop.
module tb_req_fifo_bank;

  localparam int DW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    push;
  logic [DW-1:0] pd0, pd1, pd2, pd3;
  logic [3:0]    grant = 4'b0000;
  logic [3:0]    req;
  logic [DW-1:0] di0, di1, di2, di3;
  logic [3:0]    full;
  logic [CW-1:0] lv0, lv1, lv2, lv3;
  logic [3:0]    ovf;

  int n_tot = 0;
  int n_bad = 0;

  // Mux model controls and output log
  logic          mux_en  = 1'b1;
  logic          rr_mode = 1'b0;
  logic [1:0]    rr_last = 2'd3;
  logic [DW-1:0] log_q[$];
  logic [DW-1:0] din [4];

  req_fifo_bank dut (
    .clk(clk), .rst(rst), .push(push),
    .push_data0(pd0), .push_data1(pd1), .push_data2(pd2), .push_data3(pd3),
    .grant(grant), .req(req),
    .data_in0(di0), .data_in1(di1), .data_in2(di2), .data_in3(di3),
    .full(full), .level0(lv0), .level1(lv1), .level2(lv2), .level3(lv3),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  assign din[0] = di0;
  assign din[1] = di1;
  assign din[2] = di2;
  assign din[3] = di3;

  function automatic logic [3:0] arb(input logic [3:0] r, input logic rr, input logic [1:0] last);
    logic [3:0] g;
    g = 4'b0000;
    if (!rr) begin
      for (int i = 3; i >= 0; i--) if (r[i]) g = 4'b0001 << i;
    end else begin
      for (int k = 4; k >= 1; k--) begin
        int idx;
        idx = (int'(last) + k) % 4;
        if (r[idx]) g = 4'b0001 << idx;
      end
    end
    return g;
  endfunction

  // Downstream mux: samples req, registers a one-hot grant, logs the word taken.
  always @(posedge clk) begin : mux_model
    logic [3:0] g;
    g = mux_en ? arb(req, rr_mode, rr_last) : 4'b0000;
    grant <= g;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) begin
        log_q.push_back(din[i]);
        if (rr_mode) rr_last <= 2'(i);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 8'hxx;
  endfunction

  logic [DW-1:0] rr_exp [12] = '{8'h01, 8'h11, 8'h21, 8'h31,
                                 8'h02, 8'h12, 8'h22, 8'h32,
                                 8'h03, 8'h13, 8'h23, 8'h33};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b0; push = 4'b0000;
    pd0 = '0; pd1 = '0; pd2 = '0; pd3 = '0;

    // Reset and idle
    step(2);
    chk("rst_req", req, 4'b0000);
    chk("rst_lvl0", lv0, 0);
    chk("rst_ovf", ovf, 4'b0000);
    rst = 1'b1;
    step(2);
    chk("idle_req", req, 4'b0000);
    chk("idle_full", full, 4'b0000);
    chk("idle_ovf", ovf, 4'b0000);
    chk("idle_lvls", {lv0, lv1, lv2, lv3}, 0);
    chk("idle_data", {di0, di1, di2, di3}, 0);

    // Single word on ch2, fixed priority
    push = 4'b0100; pd2 = 8'hA5;
    step(1);
    push = 4'b0000;
    chk("t2_req_on", req, 4'b0100);
    chk("t2_lvl", lv2, 1);
    chk("t2_head", di2, 8'hA5);
    step(1);
    chk("t2_req_wait", req, 4'b0000);
    chk("t2_grant", grant, 4'b0100);
    chk("t2_head_held", di2, 8'hA5);
    step(1);
    chk("t2_lvl_pop", lv2, 0);
    chk("t2_req_off", req, 4'b0000);
    step(3);
    chk("t2_cnt", log_q.size(), 1);
    chk("t2_word", log_at(0), 8'hA5);
    log_q.delete();

    // Two channels in the same cycle, fixed priority
    push = 4'b0011; pd0 = 8'h11; pd1 = 8'h22;
    step(1);
    push = 4'b0000;
    chk("t3_req", req, 4'b0011);
    step(1);
    chk("t3_grant0", grant, 4'b0001);
    chk("t3_req_wait", req, 4'b0000);
    step(1);
    chk("t3_reoffer", req, 4'b0010);
    chk("t3_lvl0", lv0, 0);
    chk("t3_lvl1", lv1, 1);
    chk("t3_head1", di1, 8'h22);
    step(4);
    chk("t3_cnt", log_q.size(), 2);
    chk("t3_w0", log_at(0), 8'h11);
    chk("t3_w1", log_at(1), 8'h22);
    chk("t3_lvl1_end", lv1, 0);
    log_q.delete();

    // Fill ch3 to DEPTH, then overflow
    mux_en = 1'b0;
    push = 4'b1000;
    for (int k = 1; k <= 4; k++) begin
      pd3 = 8'(k);
      step(1);
    end
    chk("t4_full", full, 4'b1000);
    chk("t4_lvl", lv3, 4);
    chk("t4_ovf_pre", ovf, 4'b0000);
    pd3 = 8'h05;
    step(1);
    push = 4'b0000;
    chk("t4_full2", full, 4'b1000);
    chk("t4_ovf", ovf, 4'b1000);
    chk("t4_lvl2", lv3, 4);
    mux_en = 1'b1;
    step(12);
    chk("t4_cnt", log_q.size(), 4);
    for (int k = 0; k < 4; k++) chk("t4_order", log_at(k), 8'(k + 1));
    chk("t4_lvl_end", lv3, 0);
    chk("t4_full_end", full, 4'b0000);
    chk("t4_ovf_sticky", ovf, 4'b1000);
    log_q.delete();

    // All four channels, three words each, round-robin
    mux_en = 1'b0; rr_mode = 1'b1;
    push = 4'b1111;
    for (int k = 1; k <= 3; k++) begin
      pd0 = 8'(8'h00 + k); pd1 = 8'(8'h10 + k);
      pd2 = 8'(8'h20 + k); pd3 = 8'(8'h30 + k);
      step(1);
    end
    push = 4'b0000;
    chk("t5_lvls", {lv0, lv1, lv2, lv3}, {3'd3, 3'd3, 3'd3, 3'd3});
    mux_en = 1'b1;
    step(30);
    chk("t5_cnt", log_q.size(), 12);
    for (int k = 0; k < 12; k++) chk("t5_order", log_at(k), rr_exp[k]);
    chk("t5_lvls_end", {lv0, lv1, lv2, lv3}, 0);
    log_q.delete();

    // Async reset while ch1 waits on a grant with two words stored
    rr_mode = 1'b0; mux_en = 1'b0;
    push = 4'b0010; pd1 = 8'h77;
    step(1);
    pd1 = 8'h78;
    step(1);
    push = 4'b0000;
    chk("t6_lvl_pre", lv1, 2);
    chk("t6_ovf_pre", ovf, 4'b1000);
    found = 1'b0;
    for (int c = 0; c < 4 && !found; c++) begin
      if (req[1]) begin
        mux_en = 1'b1;
        found = 1'b1;
      end else begin
        step(1);
      end
    end
    chk("t6_offer_seen", found, 1);
    step(1);
    chk("t6_grant", grant, 4'b0010);
    chk("t6_req_wait", req, 4'b0000);
    chk("t6_lvl_wait", lv1, 2);
    rst = 1'b0;
    #1;
    chk("t6_rst_req", req, 4'b0000);
    chk("t6_rst_lvl", lv1, 0);
    chk("t6_rst_ovf", ovf, 4'b0000);
    chk("t6_rst_data", di1, 0);
    #1;
    rst = 1'b1;
    log_q.delete();
    step(1);
    chk("t6_stale_lvl", lv1, 0);
    chk("t6_stale_req", req, 4'b0000);
    step(3);
    chk("t6_lvl_end", lv1, 0);
    chk("t6_ovf_end", ovf, 4'b0000);
    chk("t6_no_words", log_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule : tb_req_fifo_bank

// File: doc/req_fifo_bank.md
Name: req_fifo_bank

Overview:
- Four-channel request queue that sits directly upstream of the 4-input fixed-priority/round-robin grant mux.
- Each channel buffers words pushed by its source and presents the head word with a request line to the mux.
- A channel pops its head only when the mux's registered grant confirms that word was taken, so no word is lost or duplicated.
- Provides per-channel occupancy, full and sticky overflow status.

Parameters:
- DATA_WIDTH, 8, width of every data word (must match the downstream mux).
- DEPTH, 4, entries per channel FIFO; power of two, at least 2.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- push  input  4  per-channel write strobe.
- push_data0..push_data3  input  DATA_WIDTH each  write data, channels 0..3.
- grant  input  4  registered one-hot grant from the downstream mux.
- req  output  4  per-channel request to the mux.
- data_in0..data_in3  output  DATA_WIDTH each  head word per channel, to the mux.
- full  output  4  channel holds DEPTH entries.
- level0..level3  output  CW each  entries stored per channel.
- ovf  output  4  sticky: a push was dropped on that channel.

Behaviour:
- Reset (rst low, async): all pointers and levels go to 0; full=0, ovf=0, req=0, data_in*=0; every channel FSM goes to OFFER. Reset mid-operation flushes all stored data.
- Per-channel FIFO: circular buffer with rd_ptr/wr_ptr, each log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
- Push is accepted iff push[i]=1 and level<DEPTH at the clock edge. Push while full drops the word, sets ovf[i]=1 (held until reset), and leaves contents unchanged.
- full[i] = (level==DEPTH); a push and a pop in the same cycle on a full channel still drops the push.
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Per-channel 2-state FSM, needed because the mux's grant arrives one cycle after it samples req:
  - OFFER: req[i] = (level!=0); data_in_i = mem[rd_ptr], or 0 when empty. If req[i]=1 at the edge -> WAIT, else stay in OFFER.
  - WAIT: req[i]=0; data_in_i held at mem[rd_ptr]. At the edge, if grant[i]=1, pop (rd_ptr+1, level-1). Always -> OFFER.
- A word is therefore offered for exactly one mux sample; a losing channel re-offers the same word two cycles later.
- Per-channel peak rate is 1 word per 2 cycles; latency from push into an empty channel to req high is 1 cycle.
- grant[i]=1 while channel i is in OFFER is ignored: no pop, no state change.
- grant with more than one bit set: each channel acts only on its own bit; there is no cross-checking.
- Pushing into an empty channel in WAIT cannot occur (WAIT implies level>=1).
- Level arithmetic is unsigned CW-bit; it never underflows, because a pop occurs only in WAIT, which implies level>=1.

Decomposition:
- Shared package (modemux_pkg): NUM_CH=4, the DATA_WIDTH default, and the channel FSM state enum (OFFER, WAIT).
- One natural sub-module, req_chan_fifo: a single-channel FIFO plus FSM with push/grant in and req/data/level/full/ovf out. The top instantiates four copies and only does port wiring.

Test Plan:
- Reset then idle: release rst with no push -> req=0000, level*=0, full=0000, ovf=0000, data_in*=0.
- Push 0xA5 into ch2 with grant looped from a fixed-priority mux model -> req[2]=1 one cycle after the push; req[2]=0 the next cycle; grant=0100 pops; level2 returns to 0; mux data_out=0xA5 exactly once.
- Push 0x11 into ch0 and 0x22 into ch1 in the same cycle under fixed priority -> ch0 granted first; ch1 re-offers 0x22 two cycles later and is then granted. Output order is 0x11, 0x22 with no duplicates.
- Fill ch3 with 0x01..0x04 (DEPTH=4), then push 0x05 -> full[3]=1, ovf[3]=1, level3=4. The words then drain in order 0x01..0x04; 0x05 never appears.
- All four channels loaded with 3 words each under round-robin -> 12 grants total, per-channel FIFO order preserved, levels all 0 at the end.
- Assert rst while ch1 is in WAIT with level1=2 -> req, level1 and ovf clear immediately (async). After release, ch1 is empty and the stale grant is ignored.
